// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state, access-size
// encodings, byte-enable patterns and the store-side lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Access size encodings; 2'd3 is handled as a word everywhere.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Byte-enable patterns before lane shifting.
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Byte enables for an access of the given size at the given word offset.
  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size,
                                             input logic [1:0] offset);
    case (size)
      SZ_BYTE: return BE_BYTE << offset;
      SZ_HALF: return offset[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  // Right-justified store data replicated across every lane it may occupy.
  function automatic logic [31:0] lsu_store_data(input logic [1:0]  size,
                                                 input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data lane selection and sign/zero extension (purely combinational).
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/half, then extend to 32 bits.
  always_comb begin
    byte_lane = '0;
    case (offset)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a held CPU access into a single registered memory
// request, waits for ack (bounded by TIMEOUT_CYC), then pulses o_done.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rData,
  output logic        o_err,
  output logic        o_misalign,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned LAST_WAIT = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam int unsigned CNT_W     = (LAST_WAIT < 2) ? 1 : $clog2(LAST_WAIT + 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       off_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             load_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      load_data;
  logic             cmd_ok;
  logic             misaligned;
  logic             in_resp;

  assign cmd_ok  = i_MemRead ^ i_MemWrite;
  assign in_resp = (state == ST_RESP);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign misaligned = ((i_size == SZ_HALF) & i_addr[0]) | (i_size[1] & (|i_addr[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  // Access FSM together with the registered memory-bus fields.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          err_q  <= 1'b0;
          load_q <= 1'b0;
          if (i_valid) begin
            if (!cmd_ok) begin
              // Both or neither direction: complete with error, no bus cycle.
              err_q <= 1'b1;
              state <= ST_RESP;
            end else if (misaligned) begin
              state <= ST_RESP;
            end else begin
              state       <= ST_REQ;
              wait_cnt    <= '0;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_MemWrite;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_be    <= lsu_byte_en(i_size, i_addr[1:0]);
              o_mem_wdata <= i_MemWrite ? lsu_store_data(i_size, i_wData) : '0;
              off_q       <= i_addr[1:0];
              size_q      <= i_size;
              uns_q       <= i_unsigned;
              load_q      <= i_MemRead;
              rdata_q     <= '0;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_ack || (wait_cnt == CNT_W'(LAST_WAIT))) begin
            state       <= ST_RESP;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
            rdata_q     <= i_mem_ack ? i_mem_rdata : '0;
            err_q       <= ~i_mem_ack;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          err_q  <= 1'b0;
          load_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Remember that the completing access was a misalignment trap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= (state == ST_IDLE) & i_valid & cmd_ok & misaligned;
    end
  end

  assign o_misalign = in_resp & mis_q;
`else
  assign o_misalign = 1'b0;
`endif

  lsu_load_align u_align (
    .word       (rdata_q),
    .offset     (off_q),
    .size       (size_q),
    .is_unsigned(uns_q),
    .data       (load_data)
  );

  assign o_done  = in_resp;
  assign o_err   = in_resp & err_q;
  assign o_rData = (in_resp & load_q & ~err_q) ? load_data : '0;
  assign o_stall = i_valid & ~o_done;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural model.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_MemRead = 1'b0, i_MemWrite = 1'b0;
  logic [1:0]  i_size = '0;
  logic        i_unsigned = 1'b0;
  logic [31:0] i_addr = '0, i_wData = '0;
  logic        o_stall, o_done, o_err, o_misalign;
  logic [31:0] o_rData;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_MemRead(i_MemRead),
    .i_MemWrite(i_MemWrite), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_addr(i_addr), .i_wData(i_wData), .o_stall(o_stall), .o_done(o_done),
    .o_rData(o_rData), .o_err(o_err), .o_misalign(o_misalign),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_cycles;
    int          lat;
    bit          done;
    logic        err;
    logic        mis;
    logic [31:0] rd;
    bit          stable;
    bit          stall_ok;
    bit          idle_after;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
    int sh;
    sh = int'(addr[1:0]);
    if (size == 2'd0) return 4'((1 << sh) & 15);
    if (size == 2'd1) return (addr[1] ? 4'd12 : 4'd3);
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd1) return addr[0];
    if (size >= 2'd2) return (addr[1:0] != 2'd0);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver: one access, observations only ----------------
  // ack_delay = number of request cycles before ack; negative means never.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_delay, output obs_t o);
    o = '{we: 1'b0, addr: '0, be: '0, wdata: '0, req_cycles: 0, lat: 0, done: 1'b0,
          err: 1'b0, mis: 1'b0, rd: '0, stable: 1'b1, stall_ok: 1'b1, idle_after: 1'b0};
    i_valid = 1'b1; i_MemRead = rd; i_MemWrite = wr; i_size = size;
    i_unsigned = uns; i_addr = addr; i_wData = wdata; i_mem_rdata = rdata;
    i_mem_ack = 1'b0;
    #1;
    if (o_stall !== 1'b1) o.stall_ok = 1'b0;
    for (int c = 0; c < 20 && !o.done; c++) begin
      @(posedge i_clk); #1;
      o.lat++;
      if (o_done === 1'b1) begin
        o.done = 1'b1; o.err = o_err; o.mis = o_misalign; o.rd = o_rData;
        if (o_stall !== 1'b0 || o_mem_req !== 1'b0) o.stall_ok = 1'b0;
      end else begin
        if (o_stall !== 1'b1) o.stall_ok = 1'b0;
        if (o_mem_req === 1'b1) begin
          if (o.req_cycles == 0) begin
            o.we = o_mem_we; o.addr = o_mem_addr; o.be = o_mem_be; o.wdata = o_mem_wdata;
          end else if (o_mem_we !== o.we || o_mem_addr !== o.addr ||
                       o_mem_be !== o.be || o_mem_wdata !== o.wdata) begin
            o.stable = 1'b0;
          end
          o.req_cycles++;
          i_mem_ack = (ack_delay >= 0) && (o.req_cycles - 1 == ack_delay);
        end else begin
          i_mem_ack = 1'b0;
        end
      end
    end
    i_valid = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_mem_ack = 1'b0;
    @(posedge i_clk); #1;
    o.idle_after = (o_done === 1'b0) && (o_mem_req === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_done, o_err, o_misalign, o_stall, o_mem_req, o_mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {o_done, o_err, o_misalign, o_stall, o_mem_req, o_mem_we});
    end
    checks++;
    if ({o_rData, o_mem_addr, o_mem_be, o_mem_wdata} !== 100'b0) begin
      errors++;
      $display("FAIL reset_buses: rData=%h addr=%h be=%b wdata=%h required all zero",
               o_rData, o_mem_addr, o_mem_be, o_mem_wdata);
    end
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, o);
    checks++;
    if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b required 1111", o.be); end
    checks++;
    if (o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h required deadbeef", o.wdata); end
    checks++;
    if (o.addr !== 32'h10 || o.we !== 1'b1) begin
      errors++; $display("FAIL sw_addr_we: got %h/%b required 00000010/1", o.addr, o.we);
    end
    checks++;
    if (o.lat != 2 || !o.done) begin errors++; $display("FAIL sw_latency: got %0d required 2", o.lat); end
    checks++;
    if (o.err !== 1'b0 || !o.idle_after || !o.stall_ok) begin
      errors++; $display("FAIL sw_status: err=%b idle_after=%0d stall_ok=%0d required 0/1/1",
                         o.err, o.idle_after, o.stall_ok);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FF7F01, 0, o);
    checks++;
    if (o.rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h required ffffff80", o.rd); end
    checks++;
    if (o.be !== 4'b1000 || o.addr !== 32'h10 || o.we !== 1'b0) begin
      errors++; $display("FAIL lb_bus: be=%b addr=%h we=%b required 1000/00000010/0", o.be, o.addr, o.we);
    end
    run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FF7F01, 1, o);
    checks++;
    if (o.rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h required 00000080", o.rd); end
  endtask

  task automatic test_half();
    obs_t o;
    run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h06, 32'h1234, 32'h0, 0, o);
    checks++;
    if (o.be !== 4'b1100 || o.wdata !== 32'h12341234) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h required 1100/12341234", o.be, o.wdata);
    end
    run_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0, 32'hABCD0000, 0, o);
    checks++;
    if (o.rd !== 32'hFFFFABCD) begin errors++; $display("FAIL lh_rdata: got %h required ffffabcd", o.rd); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h55AA55AA, -1, o);
    checks++;
    if (o.req_cycles != int'(TO)) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d required %0d", o.req_cycles, TO);
    end
    checks++;
    if (!o.done || o.err !== 1'b1 || o.rd !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: done=%0d err=%b rData=%h required 1/1/00000000", o.done, o.err, o.rd);
    end
    checks++;
    if (o.lat != int'(TO) + 1 || !o.idle_after) begin
      errors++; $display("FAIL timeout_latency: got %0d required %0d", o.lat, TO + 1);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      run_access(k[0], k[0], 2'd2, 1'b0, 32'h40, 32'h1, 32'h0, 0, o);
      checks++;
      if (o.req_cycles != 0 || o.lat != 1 || o.err !== 1'b1 || o.mis !== 1'b0) begin
        errors++;
        $display("FAIL illegal_cmd%0d: req_cycles=%0d lat=%0d err=%b mis=%b required 0/1/1/0",
                 k, o.req_cycles, o.lat, o.err, o.mis);
      end
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'h13572468, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (o.req_cycles != 0 || o.lat != 1 || o.mis !== 1'b1 || o.err !== 1'b0) begin
      errors++; $display("FAIL lw_misalign_trap: req_cycles=%0d lat=%0d mis=%b err=%b required 0/1/1/0",
                         o.req_cycles, o.lat, o.mis, o.err);
    end
`else
    checks++;
    if (o.req_cycles != 1 || o.addr !== 32'h0 || o.be !== 4'b1111 || o.mis !== 1'b0) begin
      errors++; $display("FAIL lw_misalign_aligned: req_cycles=%0d addr=%h be=%b mis=%b required 1/00000000/1111/0",
                         o.req_cycles, o.addr, o.be, o.mis);
    end
    checks++;
    if (o.rd !== 32'h13572468) begin errors++; $display("FAIL lw_misalign_rdata: got %h required 13572468", o.rd); end
`endif
  endtask

  task automatic test_ack_ignored();
    bit bad;
    bad = 1'b0;
    i_mem_ack = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      if (o_done !== 1'b0 || o_mem_req !== 1'b0) bad = 1'b1;
    end
    i_mem_ack = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL ack_in_idle: got done/req activity required none"); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit saw_req, saw_done;
    saw_req = 1'b0; saw_done = 1'b0;
    i_valid = 1'b1; i_MemWrite = 1'b1; i_MemRead = 1'b0; i_size = 2'd2;
    i_addr = 32'h80; i_wData = 32'hCAFEF00D; i_mem_ack = 1'b0;
    for (int c = 0; c < 5 && !saw_req; c++) begin
      @(posedge i_clk); #1;
      saw_req = (o_mem_req === 1'b1);
    end
    checks++;
    if (!saw_req) begin errors++; $display("FAIL rst_mid_req: got no request required request"); end
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_mem_req, o_mem_we, o_done, o_mem_be} !== 7'b0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: req=%b we=%b done=%b be=%b required all 0",
                         o_mem_req, o_mem_we, o_done, o_mem_be);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_MemWrite = 1'b0;
    i_rst = 1'b0;
    repeat (4) begin
      @(posedge i_clk); #1;
      if (o_done === 1'b1 || o_mem_req === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL rst_mid_abandon: got done/req after reset required none"); end
    run_access(1'b1, 1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 32'hBEEF0000, 1, o);
    checks++;
    if (!o.done || o.rd !== 32'h0000BEEF || o.err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_next: done=%0d rData=%h err=%b required 1/0000beef/0", o.done, o.rd, o.err);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic rd, uns;
    logic [1:0] size;
    logic [31:0] addr, wd, rdata;
    int dly;
    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom; wd = $urandom; rdata = $urandom;
      dly = int'($urandom_range(0, 2));
      run_access(rd, ~rd, size, uns, addr, wd, rdata, dly, o);
      if (ref_misaligned(size, addr)) begin
        checks++;
        if (o.req_cycles != 0 || o.lat != 1 || o.mis !== 1'b1) begin
          errors++; $display("FAIL rand%0d_trap: req_cycles=%0d lat=%0d mis=%b required 0/1/1", n, o.req_cycles, o.lat, o.mis);
        end
      end else begin
        checks++;
        if (o.addr !== (addr & 32'hFFFFFFFC) || o.be !== ref_be(size, addr) || o.we !== ~rd) begin
          errors++; $display("FAIL rand%0d_bus: addr=%h be=%b we=%b required %h/%b/%b",
                             n, o.addr, o.be, o.we, addr & 32'hFFFFFFFC, ref_be(size, addr), ~rd);
        end
        if (!rd) begin
          checks++;
          if (o.wdata !== ref_wdata(size, wd)) begin
            errors++; $display("FAIL rand%0d_wdata: got %h required %h", n, o.wdata, ref_wdata(size, wd));
          end
        end else begin
          checks++;
          if (o.rd !== ref_load(size, uns, addr, rdata)) begin
            errors++; $display("FAIL rand%0d_rdata: got %h required %h", n, o.rd, ref_load(size, uns, addr, rdata));
          end
        end
        checks++;
        if (o.lat != dly + 2 || o.req_cycles != dly + 1 || o.err !== 1'b0 || o.mis !== 1'b0) begin
          errors++; $display("FAIL rand%0d_timing: lat=%0d req_cycles=%0d err=%b mis=%b required %0d/%0d/0/0",
                             n, o.lat, o.req_cycles, o.err, o.mis, dly + 2, dly + 1);
        end
        checks++;
        if (!o.stable || !o.stall_ok || !o.idle_after) begin
          errors++; $display("FAIL rand%0d_handshake: stable=%0d stall_ok=%0d idle_after=%0d required 1/1/1",
                             n, o.stable, o.stall_ok, o.idle_after);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_timeout();
    test_illegal();
    test_misalign();
    test_ack_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
